lcd_controller: RTL

//  Memory-mapped HD44780-style LCD peripheral. It sits on the CPU data bus in the top level, behind the

---
 rtl/lcd_controller.sv | 222 ++++++++++++++++++++++
 1 files changed

// File: rtl/lcd_controller.sv
// lcd_controller
//   Memory-mapped HD44780-style LCD peripheral. CPU writes are queued as
//   {RS, byte} entries in a small FIFO. A timing FSM replays each entry on the
//   LCD pins: setup, E pulse, hold, then an execute wait. Software therefore
//   never has to bit-bang the E strobe.
//
// Ports
//   clk         system clock
//   rst_n       asynchronous active-low reset
//   sel         peripheral select (decoded I/O address bit)
//   addr[1:0]   register select: 0 DATA (W), 1 CMD (W), 2 STATUS (R, write clears ovf), 3 reserved
//   wdata[31:0] CPU write data, only bits [7:0] are queued
//   wenable[3:0] CPU byte enables, only bit 0 acts as the write strobe
//   rdata[31:0] combinational register read data
//   lcd_data    LCD D[7:0]
//   lcd_ctrl    {RS, RW}, RW is always 0
//   lcd_enable  LCD E strobe, registered
//   irq_empty   high when the FIFO is empty and the FSM is idle
module lcd_controller #(
  parameter int FIFO_DEPTH       = 8,
  parameter int SETUP_CYCLES     = 2,
  parameter int PULSE_CYCLES     = 8,
  parameter int HOLD_CYCLES      = 2,
  parameter int EXEC_CYCLES      = 64,
  parameter int LONG_EXEC_CYCLES = 2048
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        sel,
  input  logic [1:0]  addr,
  input  logic [31:0] wdata,
  input  logic [3:0]  wenable,
  output logic [31:0] rdata,
  output logic [7:0]  lcd_data,
  output logic [1:0]  lcd_ctrl,
  output logic        lcd_enable,
  output logic        irq_empty
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [3:0]  DEPTH_C    = 4'(FIFO_DEPTH);
  localparam logic [15:0] SETUP_LOAD = 16'(SETUP_CYCLES - 1);
  localparam logic [15:0] PULSE_LOAD = 16'(PULSE_CYCLES - 1);
  localparam logic [15:0] HOLD_LOAD  = 16'(HOLD_CYCLES - 1);
  localparam logic [15:0] EXEC_LOAD  = 16'(EXEC_CYCLES - 1);
  localparam logic [15:0] LONG_LOAD  = 16'(LONG_EXEC_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_PULSE,
    S_HOLD,
    S_WAIT
  } state_t;

  state_t             state_q, state_d;
  logic [15:0]        cnt_q, cnt_d;
  logic [8:0]         mem_q [FIFO_DEPTH];
  logic [8:0]         mem_d [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [3:0]         count_q, count_d;
  logic               ovf_q, ovf_d;
  logic [7:0]         lcd_data_q, lcd_data_d;
  logic               rs_q, rs_d;
  logic               enable_q, enable_d;

  logic               wr_strobe;
  logic               push;
  logic               push_ok;
  logic               pop;
  logic               ovf_clr;
  logic               empty;
  logic               full;
  logic               busy;
  logic               long_cmd;
  logic [8:0]         head;
  logic               unused_inputs;

  // Only the low byte and byte-enable bit 0 take part in a write.
  assign unused_inputs = ^{wdata[31:8], wenable[3:1]};

  assign wr_strobe = sel & wenable[0];
  // DATA (addr 0) and CMD (addr 1) both push; they differ only in RS.
  assign push      = wr_strobe & ~addr[1];
  assign ovf_clr   = wr_strobe & (addr == 2'd2);
  assign empty     = (count_q == 4'd0);
  assign full      = (count_q == DEPTH_C);
  // A push that finds the FIFO full is dropped even if a pop happens on the same edge.
  assign push_ok   = push & ~full;
  assign busy      = (state_q != S_IDLE);
  assign pop       = ~busy & ~empty;
  assign head      = mem_q[rd_ptr_q];
  // Clear display and return home need the long execute wait.
  assign long_cmd  = ~rs_q & ((lcd_data_q == 8'h01) | (lcd_data_q == 8'h02));

  // FIFO storage, pointers, occupancy count and the sticky overflow flag.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    if (push_ok) begin
      mem_d[wr_ptr_q] = {~addr[0], wdata[7:0]};
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({push_ok, pop})
      2'b10:   count_d = count_q + 4'd1;
      2'b01:   count_d = count_q - 4'd1;
      default: count_d = count_q;
    endcase
    if (ovf_clr) begin
      ovf_d = 1'b0;
    end else if (push & full) begin
      ovf_d = 1'b1;
    end
  end

  // Timing FSM. One down-counter is reloaded on every state entry and the
  // state advances when it reaches zero. E is computed one cycle ahead so the
  // pin comes straight from a flop.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    lcd_data_d = lcd_data_q;
    rs_d       = rs_q;
    enable_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (pop) begin
          lcd_data_d = head[7:0];
          rs_d       = head[8];
          cnt_d      = SETUP_LOAD;
          state_d    = S_SETUP;
        end
      end
      S_SETUP: begin
        if (cnt_q == 16'd0) begin
          cnt_d    = PULSE_LOAD;
          enable_d = 1'b1;
          state_d  = S_PULSE;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      S_PULSE: begin
        if (cnt_q == 16'd0) begin
          cnt_d   = HOLD_LOAD;
          state_d = S_HOLD;
        end else begin
          cnt_d    = cnt_q - 16'd1;
          enable_d = 1'b1;
        end
      end
      S_HOLD: begin
        if (cnt_q == 16'd0) begin
          cnt_d   = long_cmd ? LONG_LOAD : EXEC_LOAD;
          state_d = S_WAIT;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      S_WAIT: begin
        if (cnt_q == 16'd0) begin
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // All state registers; reset clears the pins immediately, even mid-pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      ovf_q      <= 1'b0;
      lcd_data_q <= '0;
      rs_q       <= 1'b0;
      enable_q   <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      ovf_q      <= ovf_d;
      lcd_data_q <= lcd_data_d;
      rs_q       <= rs_d;
      enable_q   <= enable_d;
      mem_q      <= mem_d;
    end
  end

  // Register read mux; only STATUS returns data.
  always_comb begin
    rdata = '0;
    if (addr == 2'd2) begin
      rdata = {24'b0, ovf_q, busy, full, empty, count_q};
    end
  end

  assign lcd_data   = lcd_data_q;
  assign lcd_ctrl   = {rs_q, 1'b0};
  assign lcd_enable = enable_q;
  assign irq_empty  = empty & ~busy;

endmodule
